// File: rtl/fma_share_pkg.sv
// Shared types and constants for the shared-FMA issue/return controller.
// Tags are carried internally at TAG_MAX_W bits so one set of struct types
// serves every legal TAG_W; the top zero-extends on entry and truncates on exit.
package fma_share_pkg;

  localparam int FN_REC_W  = 33;
  localparam int EXC_W     = 5;
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic [FN_REC_W-1:0]  data;
    logic [EXC_W-1:0]     exc;
    logic [TAG_MAX_W-1:0] tag;
  } fma_resp_t;

  typedef struct packed {
    logic                 valid;
    logic                 sel;
    logic [TAG_MAX_W-1:0] tag;
  } fma_shadow_t;

endpackage

// File: rtl/fma_share_ctrl_if.sv
// Bundle of requester, pipeline and response signals around fma_share_ctrl.
// The controller takes the slave side; the environment takes the master side.
interface fma_share_ctrl_if #(
  parameter int TAG_W = 5
);
  import fma_share_pkg::*;

  logic                req0_valid, req1_valid;
  logic                req0_ready, req1_ready;
  logic [TAG_W-1:0]    req0_tag, req1_tag;
  logic [2:0]          req0_rm, req1_rm;
  logic [1:0]          req0_op, req1_op;

  logic                fu_in_valid;
  logic                fu_in_sel;
  logic [2:0]          fu_in_rm;
  logic [1:0]          fu_in_op;
  logic                fu_out_valid;
  logic [FN_REC_W-1:0] fu_out_data;
  logic [EXC_W-1:0]    fu_out_exc;

  logic                resp0_valid, resp1_valid;
  logic                resp0_ready, resp1_ready;
  logic [FN_REC_W-1:0] resp0_data, resp1_data;
  logic [EXC_W-1:0]    resp0_exc, resp1_exc;
  logic [TAG_W-1:0]    resp0_tag, resp1_tag;

  logic                err;

  modport master (
    output req0_valid, req1_valid, req0_tag, req1_tag, req0_rm, req1_rm, req0_op, req1_op,
    input  req0_ready, req1_ready,
    input  fu_in_valid, fu_in_sel, fu_in_rm, fu_in_op,
    output fu_out_valid, fu_out_data, fu_out_exc,
    input  resp0_valid, resp1_valid, resp0_data, resp1_data, resp0_exc, resp1_exc,
    input  resp0_tag, resp1_tag,
    output resp0_ready, resp1_ready,
    input  err
  );

  modport slave (
    input  req0_valid, req1_valid, req0_tag, req1_tag, req0_rm, req1_rm, req0_op, req1_op,
    output req0_ready, req1_ready,
    output fu_in_valid, fu_in_sel, fu_in_rm, fu_in_op,
    input  fu_out_valid, fu_out_data, fu_out_exc,
    output resp0_valid, resp1_valid, resp0_data, resp1_data, resp0_exc, resp1_exc,
    output resp0_tag, resp1_tag,
    input  resp0_ready, resp1_ready,
    output err
  );

endinterface

// File: rtl/fma_share_resp_fifo.sv
// Per-requester response FIFO: DEPTH entries of fma_resp_t, show-ahead head.
// A push and a pop in the same cycle are both honoured, even when full,
// because the pop frees the slot that the push writes.
module fma_share_resp_fifo
  import fma_share_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push_i,
  input  fma_resp_t push_data_i,
  input  logic      pop_i,
  output logic      valid_o,
  output fma_resp_t head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fma_resp_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Credits upstream make a push into a full FIFO without a pop unreachable.
  assert property (@(posedge clock) disable iff (reset)
                   !(push_i && !pop_i && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/fma_share_ctrl.sv
// Shares one fixed-latency FMA pipeline between two requesters: round-robin
// issue, shadow pipe tracking owner/tag, per-requester response FIFOs guarded
// by credits. Optional perf counters are built when FMA_SHARE_PERF_EN is set.
module fma_share_ctrl
  import fma_share_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int RESP_DEPTH = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clock,
  input  logic             reset,
  fma_share_ctrl_if.slave  bus
`ifdef FMA_SHARE_PERF_EN
  ,
  output logic [15:0]      conflict_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int CRED_W = $clog2(RESP_DEPTH + 1);

  logic             req_valid  [2];
  logic [TAG_W-1:0] req_tag    [2];
  logic             resp_ready [2];
  logic             eligible   [2];
  logic             resp_valid [2];
  fma_resp_t        resp_head  [2];
  logic [CRED_W-1:0] credit    [2];

  logic [1:0]  grant;
  logic        prio_q, prio_d;
  fma_shadow_t shadow_q [LATENCY];
  fma_shadow_t shadow_in, tail;
  fma_resp_t   push_data;
  logic        err_q;

  assign req_valid[0]  = bus.req0_valid;
  assign req_valid[1]  = bus.req1_valid;
  assign req_tag[0]    = bus.req0_tag;
  assign req_tag[1]    = bus.req1_tag;
  assign resp_ready[0] = bus.resp0_ready;
  assign resp_ready[1] = bus.resp1_ready;

  // Round-robin grant; the pointer always moves to the requester not granted.
  always_comb begin
    grant  = 2'b00;
    prio_d = prio_q;
    if (eligible[0] && eligible[1]) begin
      grant[prio_q] = 1'b1;
      prio_d        = ~prio_q;
    end else if (eligible[0]) begin
      grant[0] = 1'b1;
      prio_d   = 1'b1;
    end else if (eligible[1]) begin
      grant[1] = 1'b1;
      prio_d   = 1'b0;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

  assign shadow_in.valid = |grant;
  assign shadow_in.sel   = grant[1];
  assign shadow_in.tag   = grant[1] ? TAG_MAX_W'(req_tag[1]) :
                           grant[0] ? TAG_MAX_W'(req_tag[0]) : '0;

  // Shadow of the pipeline: advances every cycle, the FMA never stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) shadow_q[i] <= '0;
    end else begin
      shadow_q[0] <= shadow_in;
      for (int i = 1; i < LATENCY; i++) shadow_q[i] <= shadow_q[i-1];
    end
  end

  assign tail           = shadow_q[LATENCY-1];
  assign push_data.data = bus.fu_out_data;
  assign push_data.exc  = bus.fu_out_exc;
  assign push_data.tag  = tail.tag;

  // Sticky flag for a result strobe that disagrees with the shadow pipe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else if (bus.fu_out_valid != tail.valid) err_q <= 1'b1;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : gen_req
    logic [CRED_W-1:0] credit_q, credit_d;
    logic              pop, push, fifo_valid;
    fma_resp_t         fifo_head;

    assign pop          = fifo_valid && resp_ready[gi];
    assign push         = tail.valid && (tail.sel == 1'(gi));
    assign eligible[gi] = !reset && req_valid[gi] && (credit_q != '0);

    // Credit count: one per free response slot not yet claimed by an issue.
    always_comb begin
      credit_d = credit_q;
      if (grant[gi] && !pop)      credit_d = credit_q - 1'b1;
      else if (!grant[gi] && pop) credit_d = credit_q + 1'b1;
    end

    // Credit register, full at reset.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) credit_q <= CRED_W'(RESP_DEPTH);
      else       credit_q <= credit_d;
    end

    fma_share_resp_fifo #(.DEPTH(RESP_DEPTH)) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .valid_o     (fifo_valid),
      .head_o      (fifo_head)
    );

    assign resp_valid[gi] = fifo_valid;
    assign resp_head[gi]  = fifo_head;
    assign credit[gi]     = credit_q;
  end

  assign bus.req0_ready  = grant[0];
  assign bus.req1_ready  = grant[1];
  assign bus.fu_in_valid = |grant;
  assign bus.fu_in_sel   = grant[1];
  assign bus.fu_in_rm    = grant[1] ? bus.req1_rm : grant[0] ? bus.req0_rm : 3'd0;
  assign bus.fu_in_op    = grant[1] ? bus.req1_op : grant[0] ? bus.req0_op : 2'd0;

  assign bus.resp0_valid = resp_valid[0];
  assign bus.resp0_data  = resp_head[0].data;
  assign bus.resp0_exc   = resp_head[0].exc;
  assign bus.resp0_tag   = TAG_W'(resp_head[0].tag);
  assign bus.resp1_valid = resp_valid[1];
  assign bus.resp1_data  = resp_head[1].data;
  assign bus.resp1_exc   = resp_head[1].exc;
  assign bus.resp1_tag   = TAG_W'(resp_head[1].tag);
  assign bus.err         = err_q;

`ifdef FMA_SHARE_PERF_EN
  logic [15:0] conflict_cnt_q, stall_cnt_q;

  // Saturating counters of contention and credit starvation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflict_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (req_valid[0] && req_valid[1] && conflict_cnt_q != 16'hFFFF)
        conflict_cnt_q <= conflict_cnt_q + 16'd1;
      if (((req_valid[0] && credit[0] == '0) || (req_valid[1] && credit[1] == '0)) &&
          stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fma_share_ctrl.sv
// Directed bench for fma_share_ctrl: a behavioural FMA pipeline echoes issues
// after LATENCY cycles (or values are injected by hand), and monitors log
// completed response handshakes for order/tag/data checks.
module tb_fma_share_ctrl;
  import fma_share_pkg::*;

  localparam int LATENCY = 4;

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;

  fma_share_ctrl_if #(.TAG_W(5)) bus ();

`ifdef FMA_SHARE_PERF_EN
  logic [15:0] conflict_cnt, stall_cnt;
`endif

  fma_share_ctrl #(.LATENCY(LATENCY), .RESP_DEPTH(2), .TAG_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef FMA_SHARE_PERF_EN
    ,
    .conflict_cnt (conflict_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural pipeline: result strobe LATENCY cycles after issue; data
  // encodes {sel, op, rm} of the issued operation.
  logic       env_v [LATENCY] = '{default: 1'b0};
  logic [5:0] env_i [LATENCY] = '{default: 6'd0};
  logic              inj_en, inj_valid;
  logic [32:0]       inj_data;
  logic [4:0]        inj_exc;

  always @(posedge clock) begin
    env_v[0] <= bus.fu_in_valid;
    env_i[0] <= {bus.fu_in_sel, bus.fu_in_op, bus.fu_in_rm};
    for (int i = 1; i < LATENCY; i++) begin
      env_v[i] <= env_v[i-1];
      env_i[i] <= env_i[i-1];
    end
  end

  always_comb begin
    if (inj_en) begin
      bus.fu_out_valid = inj_valid;
      bus.fu_out_data  = inj_data;
      bus.fu_out_exc   = inj_exc;
    end else begin
      bus.fu_out_valid = env_v[LATENCY-1];
      bus.fu_out_data  = {1'b1, 26'h0, env_i[LATENCY-1]};
      bus.fu_out_exc   = {2'b00, env_i[LATENCY-1][2:0]};
    end
  end

  // Response / grant logs, sampled mid-cycle.
  logic [4:0]  q0_tag[$], q1_tag[$];
  logic [32:0] q0_data[$], q1_data[$];
  logic        gq[$];

  always @(negedge clock) begin
    if (bus.resp0_valid && bus.resp0_ready) begin
      q0_tag.push_back(bus.resp0_tag);
      q0_data.push_back(bus.resp0_data);
    end
    if (bus.resp1_valid && bus.resp1_ready) begin
      q1_tag.push_back(bus.resp1_tag);
      q1_data.push_back(bus.resp1_data);
    end
    if (bus.fu_in_valid) gq.push_back(bus.fu_in_sel);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    q0_tag.delete(); q1_tag.delete(); q0_data.delete(); q1_data.delete(); gq.delete();
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req0_tag = '0; bus.req0_rm = '0; bus.req0_op = '0;
    bus.req1_valid = 0; bus.req1_tag = '0; bus.req1_rm = '0; bus.req1_op = '0;
    bus.resp0_ready = 0; bus.resp1_ready = 0;
    inj_en = 0; inj_valid = 0; inj_data = '0; inj_exc = '0;
  endtask

  // Leaves the bench at cycle 0, just after reset release.
  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (6) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bus.req0_valid = 1; bus.req0_rm = 3'd5; bus.req0_op = 2'd3;
    bus.req1_valid = 1; bus.req1_rm = 3'd6; bus.req1_op = 2'd2;
    bus.resp0_ready = 1; bus.resp1_ready = 1;
    repeat (3) tick();
    tests_run++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_ready: got %b required 00", {bus.req0_ready, bus.req1_ready});
    end
    tests_run++;
    if ({bus.fu_in_valid, bus.fu_in_sel, bus.fu_in_rm, bus.fu_in_op} !== 7'd0) begin
      tests_failed++; $display("FAIL reset_fu_in: got %b required 0", {bus.fu_in_valid, bus.fu_in_sel, bus.fu_in_rm, bus.fu_in_op});
    end
    tests_run++;
    if ({bus.resp0_valid, bus.resp1_valid, bus.err} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_resp_err: got %b required 000", {bus.resp0_valid, bus.resp1_valid, bus.err});
    end
    tests_run++;
    if (dut.credit[0] !== 2'd2 || dut.credit[1] !== 2'd2) begin
      tests_failed++; $display("FAIL reset_credit: got %0d/%0d required 2/2", dut.credit[0], dut.credit[1]);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if ({bus.req0_ready, bus.req1_ready, bus.fu_in_rm} !== 5'b10_101) begin
      tests_failed++; $display("FAIL reset_first_grant: got %b required 10101", {bus.req0_ready, bus.req1_ready, bus.fu_in_rm});
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_issue();
    apply_reset();
    clear_logs();
    inj_en = 1;
    tick(); tick();                       // cycle 2
    bus.req0_valid = 1; bus.req0_tag = 5'd5; bus.req0_rm = 3'd2; bus.req0_op = 2'd1;
    #1;
    tests_run++;
    if ({bus.req0_ready, bus.fu_in_valid, bus.fu_in_sel, bus.fu_in_rm, bus.fu_in_op} !== 8'b1_1_0_010_01) begin
      tests_failed++; $display("FAIL single_issue: got %b required 11001001", {bus.req0_ready, bus.fu_in_valid, bus.fu_in_sel, bus.fu_in_rm, bus.fu_in_op});
    end
    tick();                               // cycle 3
    bus.req0_valid = 0;
    #1;
    tests_run++;
    if (dut.credit[0] !== 2'd1) begin
      tests_failed++; $display("FAIL single_credit_dec: got %0d required 1", dut.credit[0]);
    end
    tick(); tick(); tick();               // cycle 6
    inj_valid = 1; inj_data = 33'h0_3F80_0000; inj_exc = 5'd0;
    #1;
    tests_run++;
    if (bus.resp0_valid !== 1'b0) begin
      tests_failed++; $display("FAIL single_no_bypass: got %b required 0", bus.resp0_valid);
    end
    tick();                               // cycle 7
    inj_valid = 0; inj_data = '0;
    bus.resp0_ready = 1;
    #1;
    tests_run++;
    if ({bus.resp0_valid, bus.resp0_tag, bus.resp0_exc} !== {1'b1, 5'd5, 5'd0} || bus.resp0_data !== 33'h0_3F80_0000) begin
      tests_failed++; $display("FAIL single_resp: got v=%b tag=%0d data=%h required v=1 tag=5 data=03f800000", bus.resp0_valid, bus.resp0_tag, bus.resp0_data);
    end
    tests_run++;
    if ({bus.err, bus.resp1_valid} !== 2'b00) begin
      tests_failed++; $display("FAIL single_err: got %b required 00", {bus.err, bus.resp1_valid});
    end
    tick();                               // cycle 8
    bus.resp0_ready = 0;
    #1;
    tests_run++;
    if (bus.resp0_valid !== 1'b0 || dut.credit[0] !== 2'd2) begin
      tests_failed++; $display("FAIL single_credit_back: got v=%b credit=%0d required v=0 credit=2", bus.resp0_valid, dut.credit[0]);
    end
    $display("[TB] test_single_issue done");
  endtask

  task automatic test_back_to_back();
    int k0, k1;
    logic e0, e1;
    logic [1:0] op;
    logic [2:0] rm;
    apply_reset();
    clear_logs();
    bus.resp0_ready = 1; bus.resp1_ready = 1;
    k0 = 0; k1 = 0;
    // With 2 credits and latency 4 each requester recycles a credit every
    // 6 cycles, so grants come as 0,1,0,1 then two idle cycles.
    for (int c = 0; c < 24; c++) begin
      if (c > 0) tick();
      bus.req0_valid = (k0 < 8); bus.req0_tag = 5'(k0);
      bus.req0_rm = 3'(k0); bus.req0_op = 2'(k0);
      bus.req1_valid = (k1 < 8); bus.req1_tag = 5'(16 + k1);
      bus.req1_rm = ~3'(k1); bus.req1_op = ~2'(k1);
      #1;
      e0 = (c % 6 == 0) || (c % 6 == 2);
      e1 = (c % 6 == 1) || (c % 6 == 3);
      tests_run++;
      if ({bus.req0_ready, bus.req1_ready} !== {e0, e1}) begin
        tests_failed++; $display("FAIL b2b_grant c=%0d: got %b required %b", c, {bus.req0_ready, bus.req1_ready}, {e0, e1});
      end
      if (bus.req0_ready) k0++;
      if (bus.req1_ready) k1++;
    end
    tick();
    bus.req0_valid = 0; bus.req1_valid = 0;
    repeat (10) tick();
    tests_run++;
    if (q0_tag.size() != 8 || q1_tag.size() != 8 || gq.size() != 16) begin
      tests_failed++; $display("FAIL b2b_counts: got %0d/%0d/%0d required 8/8/16", q0_tag.size(), q1_tag.size(), gq.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        rm = 3'(j); op = 2'(j);
        tests_run++;
        if (q0_tag[j] !== 5'(j) || q0_data[j] !== {1'b1, 26'h0, 1'b0, op, rm}) begin
          tests_failed++; $display("FAIL b2b_resp0 j=%0d: got tag=%0d data=%h required tag=%0d data=%h", j, q0_tag[j], q0_data[j], j, {1'b1, 26'h0, 1'b0, op, rm});
        end
        tests_run++;
        if (q1_tag[j] !== 5'(16 + j) || q1_data[j] !== {1'b1, 26'h0, 1'b1, ~op, ~rm}) begin
          tests_failed++; $display("FAIL b2b_resp1 j=%0d: got tag=%0d data=%h required tag=%0d data=%h", j, q1_tag[j], q1_data[j], 16 + j, {1'b1, 26'h0, 1'b1, ~op, ~rm});
        end
      end
      for (int j = 0; j < 16; j++) begin
        tests_run++;
        if (gq[j] !== 1'(j)) begin
          tests_failed++; $display("FAIL b2b_order j=%0d: got %b required %b", j, gq[j], 1'(j));
        end
      end
    end
    $display("[TB] test_back_to_back done");
  endtask

  // Leaves requester 1's FIFO holding tag 17 with tag 18 in flight (cycle 24).
  task automatic test_backpressure();
    int k0, k1, g1;
    apply_reset();
    clear_logs();
    bus.resp0_ready = 1; bus.resp1_ready = 0;
    k0 = 0; k1 = 0; g1 = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) tick();
      bus.req0_valid = 1; bus.req0_tag = 5'(k0 % 16); bus.req0_rm = 3'(k0); bus.req0_op = 2'(k0);
      bus.req1_valid = 1; bus.req1_tag = 5'(16 + k1); bus.req1_rm = ~3'(k1); bus.req1_op = ~2'(k1);
      #1;
      if (bus.req0_ready) k0++;
      if (bus.req1_ready) begin g1++; k1++; end
    end
    tests_run++;
    if (g1 !== 2) begin
      tests_failed++; $display("FAIL bp_grants1: got %0d required 2", g1);
    end
    tests_run++;
    if (bus.resp1_valid !== 1'b1 || bus.resp1_tag !== 5'd16) begin
      tests_failed++; $display("FAIL bp_held: got v=%b tag=%0d required v=1 tag=16", bus.resp1_valid, bus.resp1_tag);
    end
    tick();                               // cycle 20: single pop
    bus.req0_valid = 0;
    bus.req1_tag = 5'(16 + k1); bus.req1_rm = ~3'(k1); bus.req1_op = ~2'(k1);
    bus.resp1_ready = 1;
    #1;
    tests_run++;
    if (bus.req1_ready !== 1'b0) begin
      tests_failed++; $display("FAIL bp_no_credit: got %b required 0", bus.req1_ready);
    end
    g1 = 0;
    for (int c = 21; c < 25; c++) begin
      tick();
      bus.resp1_ready = 0;
      bus.req1_tag = 5'(16 + k1); bus.req1_rm = ~3'(k1); bus.req1_op = ~2'(k1);
      #1;
      if (c == 21) begin
        tests_run++;
        if (bus.resp1_tag !== 5'd17) begin
          tests_failed++; $display("FAIL bp_head_after_pop: got %0d required 17", bus.resp1_tag);
        end
      end
      if (bus.req1_ready) begin g1++; k1++; end
    end
    tests_run++;
    if (g1 !== 1) begin
      tests_failed++; $display("FAIL bp_one_grant_per_pop: got %0d required 1", g1);
    end
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_push_pop_same_cycle();
    tick();                               // cycle 25: pop 17 while 18 is pushed
    bus.req1_tag = 5'd19; bus.req1_rm = ~3'd3; bus.req1_op = ~2'd3;
    bus.resp1_ready = 1;
    #1;
    tests_run++;
    if (bus.resp1_valid !== 1'b1 || bus.resp1_tag !== 5'd17) begin
      tests_failed++; $display("FAIL pp_head: got v=%b tag=%0d required v=1 tag=17", bus.resp1_valid, bus.resp1_tag);
    end
    tick();                               // cycle 26
    bus.resp1_ready = 0;
    #1;
    tests_run++;
    if (bus.resp1_valid !== 1'b1 || bus.resp1_tag !== 5'd18 || bus.resp1_data !== {1'b1, 26'h0, 1'b1, 2'b01, 3'b101}) begin
      tests_failed++; $display("FAIL pp_new_head: got v=%b tag=%0d data=%h required v=1 tag=18 data=%h", bus.resp1_valid, bus.resp1_tag, bus.resp1_data, {1'b1, 26'h0, 1'b1, 2'b01, 3'b101});
    end
    tests_run++;
    if (bus.req1_ready !== 1'b1) begin
      tests_failed++; $display("FAIL pp_credit_freed: got %b required 1", bus.req1_ready);
    end
    tick();
    bus.req1_valid = 0;
    bus.resp1_ready = 1;
    repeat (10) tick();
    tests_run++;
    if (q1_tag.size() != 4) begin
      tests_failed++; $display("FAIL pp_count: got %0d required 4", q1_tag.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        tests_run++;
        if (q1_tag[j] !== 5'(16 + j)) begin
          tests_failed++; $display("FAIL pp_order j=%0d: got %0d required %0d", j, q1_tag[j], 16 + j);
        end
      end
    end
    tests_run++;
    if (bus.err !== 1'b0 || dut.credit[1] !== 2'd2) begin
      tests_failed++; $display("FAIL pp_final: got err=%b credit=%0d required err=0 credit=2", bus.err, dut.credit[1]);
    end
    $display("[TB] test_push_pop_same_cycle done");
  endtask

  task automatic test_err_inject();
    apply_reset();
    clear_logs();
    inj_en = 1;
    bus.resp0_ready = 0; bus.resp1_ready = 0;
    tick(); tick();                       // cycle 2
    inj_valid = 1; inj_data = 33'h1_2345_6789;
    #1;
    tests_run++;
    if (bus.err !== 1'b0) begin
      tests_failed++; $display("FAIL err_before: got %b required 0", bus.err);
    end
    tick();                               // cycle 3
    inj_valid = 0;
    #1;
    tests_run++;
    if ({bus.err, bus.resp0_valid, bus.resp1_valid} !== 3'b100) begin
      tests_failed++; $display("FAIL err_set: got %b required 100", {bus.err, bus.resp0_valid, bus.resp1_valid});
    end
    repeat (4) tick();
    tests_run++;
    if ({bus.err, bus.resp0_valid, bus.resp1_valid} !== 3'b100) begin
      tests_failed++; $display("FAIL err_sticky: got %b required 100", {bus.err, bus.resp0_valid, bus.resp1_valid});
    end
    $display("[TB] test_err_inject done");
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    clear_logs();
    bus.req0_valid = 1; bus.req0_tag = 5'd1; bus.req1_valid = 1; bus.req1_tag = 5'd17;
    #1;                                   // cycle 0: grant 0
    tick();                               // cycle 1: grant 1
    bus.req0_tag = 5'd2;
    tick();                               // cycle 2: grant 0
    bus.req1_tag = 5'd18;
    #1;
    tests_run++;
    if (bus.req0_ready !== 1'b1 || gq.size() != 2) begin
      tests_failed++; $display("FAIL mid_setup: got ready0=%b grants=%0d required 1/2", bus.req0_ready, gq.size());
    end
    tick();                               // cycle 3: reset
    bus.req0_valid = 0; bus.req1_valid = 0;
    reset = 1'b1;
    #1;
    tests_run++;
    if (dut.credit[0] !== 2'd2 || dut.credit[1] !== 2'd2 || dut.prio_q !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset_state: got c0=%0d c1=%0d prio=%b required 2/2/0", dut.credit[0], dut.credit[1], dut.prio_q);
    end
    tests_run++;
    if ({bus.resp0_valid, bus.resp1_valid, bus.err} !== 3'b000) begin
      tests_failed++; $display("FAIL mid_reset_outputs: got %b required 000", {bus.resp0_valid, bus.resp1_valid, bus.err});
    end
    tick();                               // cycle 4: release, stale result arrives
    reset = 1'b0;
    tick();                               // cycle 5
    bus.req0_valid = 1; bus.req0_tag = 5'd3; bus.req1_valid = 1; bus.req1_tag = 5'd19;
    #1;
    tests_run++;
    if (bus.err !== 1'b1) begin
      tests_failed++; $display("FAIL mid_stale_err: got %b required 1", bus.err);
    end
    tests_run++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      tests_failed++; $display("FAIL mid_first_conflict: got %b required 10", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick(); tick();                       // cycle 8: stale results all gone
    #1;
    tests_run++;
    if ({bus.resp0_valid, bus.resp1_valid} !== 2'b00) begin
      tests_failed++; $display("FAIL mid_no_stale_push: got %b required 00", {bus.resp0_valid, bus.resp1_valid});
    end
    $display("[TB] test_reset_midflight done");
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_issue();
    test_back_to_back();
    test_backpressure();
    test_push_pop_same_cycle();
    test_err_inject();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
